// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage F/D/E/M/W pipeline.
// Arbitrates data-memory wait, multi-cycle execute ops, taken branches and
// load-use hazards, and owns the multi-cycle-op occupancy counter.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MC_LATENCY = 4,
  localparam int CNT_W     = $clog2(MC_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             mem_read_e,
  input  logic             pc_src_e,
  input  logic             mc_start_e,
  input  logic             mem_ready_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             mc_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_events,
`endif
  output logic             mc_done
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;
  logic             lu_haz;
  logic             mc_hold;

  // Hazard terms, priority arbitration of stall/flush rows, and FSM next state.
  // Everything is forced low while reset is asserted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_w  = 1'b0;
    mc_busy  = 1'b0;
    mc_done  = 1'b0;
    mem_wait = ~mem_ready_m;
    lu_haz   = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    mc_hold  = ((state_q == IDLE) && mc_start_e) ||
               ((state_q == BUSY) && (cnt_q > CNT_W'(1)));
    if (reset) begin
      mc_busy = (state_q == BUSY);
      if (mem_wait) begin
        // Whole pipe holds; W gets a bubble since M has nothing to retire.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (mc_hold) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (pc_src_e) begin
        // A load-use stall on a wrong-path instruction is pointless; drop it.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu_haz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      // The counter only advances when memory is not holding the pipe.
      if (!mem_wait) begin
        case (state_q)
          IDLE: begin
            if (mc_start_e) begin
              cnt_d   = CNT_W'(MC_LATENCY - 1);
              state_d = BUSY;
            end
          end
          BUSY: begin
            if (cnt_q > CNT_W'(1)) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              mc_done = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  // State and counter registers; an asserted reset abandons any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;

  // Saturating counts of fetch-stall cycles and applied branch flushes
  // (flush_d is asserted only by the branch row).
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_f && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_d && (flush_events_q != '1)) flush_events_d = flush_events_q + 16'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with constant
// expectations plus randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int REG_W      = 5;
  localparam int MC_LATENCY = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [REG_W-1:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
  logic             mem_read_e = 1'b0, pc_src_e = 1'b0, mc_start_e = 1'b0, mem_ready_m = 1'b1;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, mc_busy, mc_done;
  logic s2_f, s2_d, s2_e, s2_m, f2_d, f2_e, f2_m, f2_w, busy2, done2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, stall_cycles2;
  logic [15:0] flush_events, flush_events2;
  logic [31:0] m_stalls;
  logic [15:0] m_flushes;
`endif
  logic [9:0] dut_vec, dut2_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: is an op occupying E, and how many E cycles it has used.
  bit m_in_op;
  int m_age;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(REG_W), .MC_LATENCY(MC_LATENCY)) dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
    .mem_ready_m(mem_ready_m), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e),
    .flush_m(flush_m), .flush_w(flush_w), .mc_busy(mc_busy),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .mc_done(mc_done));

  // Second instance at the minimum latency.
  pipe_hazard_ctrl #(.REG_W(REG_W), .MC_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
    .mem_ready_m(mem_ready_m), .stall_f(s2_f), .stall_d(s2_d),
    .stall_e(s2_e), .stall_m(s2_m), .flush_d(f2_d), .flush_e(f2_e),
    .flush_m(f2_m), .flush_w(f2_w), .mc_busy(busy2),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles2), .flush_events(flush_events2),
`endif
    .mc_done(done2));

  // Bit order: {sf, sd, se, sm, fd, fe, fm, fw, busy, done}
  assign dut_vec  = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, mc_busy, mc_done};
  assign dut2_vec = {s2_f, s2_d, s2_e, s2_m, f2_d, f2_e, f2_m, f2_w, busy2, done2};

  function automatic logic [9:0] expect_out();
    logic sf, sd, se, sm, fd, fe, fm, fw, busy, done;
    bit   hazard, mc_stall;
    {sf, sd, se, sm, fd, fe, fm, fw, busy, done} = '0;
    if (!reset) return '0;
    hazard   = mem_read_e && (rd_e != 0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    mc_stall = m_in_op ? (m_age < MC_LATENCY - 1) : mc_start_e;
    busy     = m_in_op;
    if (!mem_ready_m) begin
      {sf, sd, se, sm, fw} = 5'b11111;
    end else begin
      done = m_in_op && (m_age == MC_LATENCY - 1);
      if (mc_stall)        {sf, sd, se, fm} = 4'b1111;
      else if (pc_src_e)   {fd, fe} = 2'b11;
      else if (hazard)     {sf, sd, fe} = 3'b111;
    end
    return {sf, sd, se, sm, fd, fe, fm, fw, busy, done};
  endfunction

  task automatic model_reset();
    m_in_op = 0;
    m_age   = 0;
`ifdef HAZARD_PERF_CNT_EN
    m_stalls  = '0;
    m_flushes = '0;
`endif
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_advance();
    logic [9:0] e;
    e = expect_out();
    if (!reset) return;
`ifdef HAZARD_PERF_CNT_EN
    if (e[9] && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
    if (e[5] && m_flushes != 16'hFFFF) m_flushes = m_flushes + 1;
`endif
    if (!mem_ready_m) return;
    if (m_in_op) begin
      if (m_age < MC_LATENCY - 1) m_age++;
      else m_in_op = 0;
    end else if (mc_start_e) begin
      m_in_op = 1;
      m_age   = 1;
    end
  endtask

  // Stimulus word: {rs1, rs2, rd, mem_read, pc_src, mc_start, mem_ready}
  task automatic drive(input logic [18:0] s);
    {rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, mc_start_e, mem_ready_m} = s;
    #4;
  endtask

  task automatic finish_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    {rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, mc_start_e, mem_ready_m} = {5'd3, 5'd3, 5'd3, 4'b1010};
    #3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_vec !== 10'b0 || dut2_vec !== 10'b0) begin
        errors++;
        $display("FAIL reset_low cyc%0d got %b/%b want 0", i, dut_vec, dut2_vec);
      end
      @(posedge clk);
      #1;
    end
    drive({15'd0, 4'b0001});
    reset = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 10'b0) begin
      errors++;
      $display("FAIL reset_release got %b want %b", dut_vec, 10'b0);
    end
    finish_cycle();
  endtask

  task automatic test_load_use();
    logic [18:0] stim [5] = '{{5'd3, 5'd5, 5'd5, 4'b1001}, {5'd0, 5'd7, 5'd0, 4'b1001},
                              {5'd5, 5'd1, 5'd5, 4'b1001}, {5'd2, 5'd3, 5'd5, 4'b1001},
                              {5'd5, 5'd5, 5'd5, 4'b0001}};
    logic [9:0]  want [5] = '{10'b1100010000, 10'b0, 10'b1100010000, 10'b0, 10'b0};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i]);
      checks++;
      if (dut_vec !== want[i]) begin
        errors++;
        $display("FAIL load_use cyc%0d got %b want %b", i, dut_vec, want[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_multicycle();
    logic [9:0] want [5] = '{10'b1110001000, 10'b1110001010, 10'b1110001010,
                             10'b0000000011, 10'b0};
    for (int i = 0; i < 5; i++) begin
      drive({15'd0, 2'b00, (i < 4) ? 1'b1 : 1'b0, 1'b1});
      checks++;
      if (dut_vec !== want[i]) begin
        errors++;
        $display("FAIL multicycle cyc%0d got %b want %b", i, dut_vec, want[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_mem_wait_mc();
    logic [9:0] want [7] = '{10'b1110001000, 10'b1111000110, 10'b1111000110,
                             10'b1110001010, 10'b1110001010, 10'b0000000011, 10'b0};
    for (int i = 0; i < 7; i++) begin
      drive({15'd0, 2'b00, (i < 6) ? 1'b1 : 1'b0, (i == 1 || i == 2) ? 1'b0 : 1'b1});
      checks++;
      if (dut_vec !== want[i]) begin
        errors++;
        $display("FAIL mem_wait_mc cyc%0d got %b want %b", i, dut_vec, want[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_branch_lu();
    logic [18:0] stim [7] = '{{5'd5, 5'd0, 5'd5, 4'b1101}, {5'd5, 5'd0, 5'd5, 4'b1001},
                              {15'd0, 4'b0111}, {15'd0, 4'b0011}, {15'd0, 4'b0011},
                              {5'd5, 5'd0, 5'd5, 4'b1011}, {15'd0, 4'b0001}};
    logic [9:0]  want [7] = '{10'b0000110000, 10'b1100010000, 10'b1110001000,
                              10'b1110001010, 10'b1110001010, 10'b1100010011, 10'b0};
    for (int i = 0; i < 7; i++) begin
      drive(stim[i]);
      checks++;
      if (dut_vec !== want[i]) begin
        errors++;
        $display("FAIL branch_lu cyc%0d got %b want %b", i, dut_vec, want[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] want [9] = '{10'b1110001000, 10'b1110001010, 10'b1110001010, 10'b0000000011,
                             10'b1110001000, 10'b1110001010, 10'b1110001010, 10'b0000000011,
                             10'b0};
    for (int i = 0; i < 9; i++) begin
      drive({15'd0, 2'b00, (i < 8) ? 1'b1 : 1'b0, 1'b1});
      checks++;
      if (dut_vec !== want[i]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d got %b want %b", i, dut_vec, want[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_latency2();
    logic [9:0] want [5] = '{10'b1110001000, 10'b0000000011, 10'b1110001000,
                             10'b0000000011, 10'b0};
    for (int i = 0; i < 2; i++) begin
      drive({15'd0, 4'b0001});
      finish_cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive({15'd0, 2'b00, (i < 4) ? 1'b1 : 1'b0, 1'b1});
      checks++;
      if (dut2_vec !== want[i]) begin
        errors++;
        $display("FAIL latency2 cyc%0d got %b want %b", i, dut2_vec, want[i]);
      end
      finish_cycle();
    end
  endtask

  task automatic test_reset_mid_op();
    logic [9:0] want [2] = '{10'b1110001000, 10'b1110001010};
    for (int i = 0; i < 2; i++) begin
      drive({15'd0, 4'b0011});
      checks++;
      if (dut_vec !== want[i]) begin
        errors++;
        $display("FAIL mid_op_setup cyc%0d got %b want %b", i, dut_vec, want[i]);
      end
      finish_cycle();
    end
    // Counter now holds 2; pull reset between clock edges.
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_op got %b want %b", dut_vec, 10'b0);
    end
    model_reset();
    @(posedge clk);
    #1 mc_start_e = 1'b0;
    #1 reset = 1'b1;
    #2;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset got %0d want 0", stall_cycles);
    end
`endif
    finish_cycle();
    for (int i = 0; i < 5; i++) begin
      drive({15'd0, 4'b0001});
      checks++;
      if (dut_vec !== 10'b0) begin
        errors++;
        $display("FAIL after_reset cyc%0d got %b want %b", i, dut_vec, 10'b0);
      end
      finish_cycle();
    end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive({5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2),
             1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 8)});
      exp = expect_out();
      checks++;
      if (dut_vec !== exp) begin
        errors++;
        $display("FAIL random cyc%0d got %b want %b", i, dut_vec, exp);
      end
      finish_cycle();
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== m_stalls || flush_events !== m_flushes) begin
      errors++;
      $display("FAIL perf_counts got %0d/%0d want %0d/%0d",
               stall_cycles, flush_events, m_stalls, m_flushes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multicycle();
    test_mem_wait_mc();
    test_branch_lu();
    test_back_to_back();
    test_latency2();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
